overlay_timing_gen: RTL and testbench
=====================================

// Module: overlay_timing_gen
// PURPOSE
//  Parametrised video timing generator with a rectangular image-overlay mixer, for the HDMI output path.
//  Generates DE/HSYNC/VSYNC from programmable porch/sync widths and selectable polarity.
//  Blends a streamed overlay image (ready/valid, from the DDR reader) over a background colour.
//  Supersedes the fixed hsync/vsync/DE/dataWrite chain.
// PARAMETERS
//  H_ACTIVE 1280 active pixels/line;  H_FP 110;  H_SYNC 40;  H_BP 220   (clocks)
//  V_ACTIVE 720  active lines/frame;  V_FP 5;    V_SYNC 5;   V_BP 20    (lines)
//  HSYNC_POL 1  active level of HSYNC;  VSYNC_POL 1  active level of VSYNC
//  CNT_W 12  counter/coordinate width;  DATA_W 24  RGB width
//  OVL_W 256  overlay width (pixels);  OVL_H 256  overlay height (lines)
// PORTS
//  clock        in   1       pixel clock
//  reset        in   1       async, active-high
//  enable       in   1       0: counters held at 0, outputs inactive, FSM -> SEEK
//  ovl_en       in   1       overlay enable (latched at frame start)
//  ovl_x/ovl_y  in   CNT_W   overlay top-left (latched at frame start)
//  key_en       in   1       colour-key transparency enable
//  key_colour   in   DATA_W  transparent colour
//  bg_colour    in   DATA_W  background colour
//  pix_data     in   DATA_W  overlay pixel;  pix_sof in 1  marks first pixel of an image
//  pix_valid    in   1       source valid;   pix_ready out 1  sink accepts (combinational)
//  DE, HSYNC, VSYNC  out 1   registered timing outputs
//  data         out  DATA_W  registered RGB
//  frame_start  out  1       1-cycle pulse aligned with first active pixel of frame
//  underflow    out  1       sticky: window pixel due but none valid
//  sync_err     out  1       sticky: pix_sof seen mid-image
//  config_err   out  1       1-cycle pulse: latched window exceeds active area
// BEHAVIOUR
//  Counters: h 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP); v advances when h wraps, 0..V_TOTAL-1, wraps to 0.
//  Active: h<H_ACTIVE && v<V_ACTIVE.  HSYNC active: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.  VSYNC likewise on v.
//  All outputs registered; 1 clock latency from counters; DE/HSYNC/VSYNC/data/frame_start mutually aligned.
//  Reset/enable=0: h=v=0, DE=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL, data=0, frame_start=0, pix_ready=0, FSM=SEEK.
//   underflow/sync_err cleared only by reset.
//  At h=0,v=0: latch ovl_en/ovl_x/ovl_y; if ovl_x+OVL_W>H_ACTIVE or ovl_y+OVL_H>V_ACTIVE, latched en=0 and pulse config_err.
//  in_win: latched en && ovl_x<=h<ovl_x+OVL_W && ovl_y<=v<ovl_y+OVL_H; origin = in_win at (ovl_x,ovl_y).
//  FSM:
//   SEEK: pix_ready=!pix_sof (discard non-SOF beats); pix_valid&&pix_sof -> ARMED (SOF beat held, not consumed).
//   ARMED: pix_ready=origin; at origin: valid&&sof -> consume, RUNNING; else underflow=1, stay ARMED.
//   RUNNING: pix_ready=in_win && !pix_sof; in_win&&!valid -> underflow=1, show bg;
//            valid&&sof inside window after origin -> sync_err=1, ARMED (beat not consumed);
//            last window pixel consumed -> ARMED.
//  Mixing (active region): in_win && beat consumed && !(key_en && pix_data==key_colour) -> data=pix_data; else data=bg_colour.
//  Blanking: data=0.  Frame with no consumed window beats shows bg in window.
//  Simultaneous: counter wrap and frame latch in same cycle use new-frame values; enable fall mid-line aborts line immediately.
// TESTING
//  (Small params: H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1,OVL_W=2,OVL_H=2.)
//  reset then enable=1 -> HSYNC high at h=10..11 (1 clock later on pins), period 14; VSYNC 14 clocks at v=5; DE 8/14 on lines 0-3.
//  HSYNC_POL=0 -> HSYNC idles 1 during reset and pulses low; frame_start once per 98 clocks.
//  ovl_x=3,ovl_y=1, stream 4 beats A,B,C,D (sof on A) -> data A,B at (3,1),(4,1); C,D at (3,2),(4,2); else bg.
//  key_en=1,key_colour=B -> (4,1) shows bg_colour; beat B still consumed.
//  pix_valid=0 at (4,1) -> underflow=1 sticky, bg shown; sof on beat 3 -> sync_err=1, next frame realigns.
//  ovl_x=7 -> config_err pulse at frame start, pix_ready stays 0, no beats consumed; async reset mid-line -> all outputs reset values.

Source files
------------

// File: rtl/overlay_timing_gen.sv
// Video timing generator with a streamed rectangular overlay mixed over
// a background colour; all pins registered one clock after the counters.
module overlay_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 12,
  parameter int DATA_W    = 24,
  parameter int OVL_W     = 256,
  parameter int OVL_H     = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              ovl_en,
  input  logic [CNT_W-1:0]  ovl_x,
  input  logic [CNT_W-1:0]  ovl_y,
  input  logic              key_en,
  input  logic [DATA_W-1:0] key_colour,
  input  logic [DATA_W-1:0] bg_colour,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              DE,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [DATA_W-1:0] data,
  output logic              frame_start,
  output logic              underflow,
  output logic              sync_err,
  output logic              config_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_W:0] wide_t;
  typedef enum logic [1:0] {SEEK, ARMED, RUNNING} state_e;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic              lat_en_q, lat_en_d;
  logic [CNT_W-1:0]  lat_x_q, lat_x_d, lat_y_q, lat_y_d;
  state_e            st_q, st_d;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic              fs_q, fs_d, cfg_q, cfg_d;
  logic              uf_q, uf_d, se_q, se_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic        frame_pt, h_last, v_last, win_bad;
  logic        cur_en, in_win, origin, last_px;
  logic        active, hs_on, vs_on;
  logic        take, show, uf_set, se_set;
  logic [CNT_W-1:0] cur_x, cur_y;
  wide_t       hw, vw, xw, yw;

  always_comb begin
    hw = wide_t'(h_q);
    vw = wide_t'(v_q);
    frame_pt = (h_q == '0) && (v_q == '0);
    h_last = hw == wide_t'(H_TOTAL - 1);
    v_last = vw == wide_t'(V_TOTAL - 1);
    h_d = h_q + C_ONE;
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + C_ONE;
    end
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end
  end

  // The frame-start cycle already uses the freshly sampled window.
  always_comb begin
    win_bad = (wide_t'(ovl_x) + wide_t'(OVL_W) > wide_t'(H_ACTIVE))
           || (wide_t'(ovl_y) + wide_t'(OVL_H) > wide_t'(V_ACTIVE));
    cur_en = frame_pt ? (ovl_en && !win_bad) : lat_en_q;
    cur_x  = frame_pt ? ovl_x : lat_x_q;
    cur_y  = frame_pt ? ovl_y : lat_y_q;
    lat_en_d = cur_en;
    lat_x_d  = cur_x;
    lat_y_d  = cur_y;
    xw = wide_t'(cur_x);
    yw = wide_t'(cur_y);
    in_win = cur_en && (hw >= xw) && (hw < xw + wide_t'(OVL_W))
          && (vw >= yw) && (vw < yw + wide_t'(OVL_H));
    origin  = in_win && (h_q == cur_x) && (v_q == cur_y);
    last_px = in_win && (hw == xw + wide_t'(OVL_W - 1))
           && (vw == yw + wide_t'(OVL_H - 1));
    active = (hw < wide_t'(H_ACTIVE)) && (vw < wide_t'(V_ACTIVE));
    hs_on = (hw >= wide_t'(H_ACTIVE + H_FP))
         && (hw < wide_t'(H_ACTIVE + H_FP + H_SYNC));
    vs_on = (vw >= wide_t'(V_ACTIVE + V_FP))
         && (vw < wide_t'(V_ACTIVE + V_FP + V_SYNC));
  end

  always_comb begin
    st_d = st_q;
    pix_ready = 1'b0;
    take = 1'b0;
    uf_set = 1'b0;
    se_set = 1'b0;
    unique case (st_q)
      SEEK: begin
        pix_ready = !pix_sof;
        if (pix_valid && pix_sof) st_d = ARMED;
      end
      ARMED: begin
        pix_ready = origin;
        if (origin) begin
          if (pix_valid && pix_sof) begin
            take = 1'b1;
            st_d = last_px ? ARMED : RUNNING;
          end else begin
            uf_set = 1'b1;
          end
        end
      end
      RUNNING: begin
        pix_ready = in_win && !pix_sof;
        if (in_win) begin
          if (!pix_valid) begin
            uf_set = 1'b1;
          end else if (pix_sof) begin
            se_set = 1'b1;
            st_d = ARMED;
          end else begin
            take = 1'b1;
            if (last_px) st_d = ARMED;
          end
        end
      end
      default: st_d = SEEK;
    endcase
    if (!enable || reset) begin
      st_d = SEEK;
      pix_ready = 1'b0;
      take = 1'b0;
      uf_set = 1'b0;
      se_set = 1'b0;
    end
  end

  always_comb begin
    show = take && !(key_en && (pix_data == key_colour));
    de_d = enable && active;
    hs_d = (enable && hs_on) ? HSYNC_POL : ~HSYNC_POL;
    vs_d = (enable && vs_on) ? VSYNC_POL : ~VSYNC_POL;
    fs_d = enable && frame_pt;
    cfg_d = enable && frame_pt && win_bad;
    uf_d = uf_q | uf_set;
    se_d = se_q | se_set;
    data_d = '0;
    if (enable && active) data_d = show ? pix_data : bg_colour;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      lat_en_q <= 1'b0;
      lat_x_q  <= '0;
      lat_y_q  <= '0;
      st_q     <= SEEK;
      de_q     <= 1'b0;
      hs_q     <= ~HSYNC_POL;
      vs_q     <= ~VSYNC_POL;
      fs_q     <= 1'b0;
      cfg_q    <= 1'b0;
      uf_q     <= 1'b0;
      se_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      lat_en_q <= lat_en_d;
      lat_x_q  <= lat_x_d;
      lat_y_q  <= lat_y_d;
      st_q     <= st_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      cfg_q    <= cfg_d;
      uf_q     <= uf_d;
      se_q     <= se_d;
      data_q   <= data_d;
    end
  end

  assign DE          = de_q;
  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign data        = data_q;
  assign frame_start = fs_q;
  assign config_err  = cfg_q;
  assign underflow   = uf_q;
  assign sync_err    = se_q;

endmodule

// File: tb/tb_overlay_timing_gen.sv
// Bench for overlay_timing_gen: small raster, random overlay frames
// against a frame-level model, then directed underflow/resync/reset runs.
module tb_overlay_timing_gen;
  localparam int CW = 12;
  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset, enable, ovl_en, key_en;
  logic          pix_sof, pix_valid;
  logic [CW-1:0] ovl_x, ovl_y;
  logic [DW-1:0] key_colour, bg_colour, pix_data;

  logic          pix_ready, DE, HSYNC, VSYNC;
  logic          frame_start, underflow, sync_err, config_err;
  logic [DW-1:0] data;
  logic          rdy_n, de_n, hs_n, vs_n, fs_n, uf_n, se_n, ce_n;
  logic [DW-1:0] data_n;

  always #5 clock = ~clock;

  overlay_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .CNT_W(CW), .DATA_W(DW), .OVL_W(2), .OVL_H(2)
  ) u_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ovl_en(ovl_en), .ovl_x(ovl_x), .ovl_y(ovl_y),
    .key_en(key_en), .key_colour(key_colour),
    .bg_colour(bg_colour), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .DE(DE), .HSYNC(HSYNC),
    .VSYNC(VSYNC), .data(data), .frame_start(frame_start),
    .underflow(underflow), .sync_err(sync_err),
    .config_err(config_err)
  );

  overlay_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .CNT_W(CW), .DATA_W(DW), .OVL_W(2), .OVL_H(2)
  ) u_dut_n (
    .clock(clock), .reset(reset), .enable(enable),
    .ovl_en(ovl_en), .ovl_x(ovl_x), .ovl_y(ovl_y),
    .key_en(key_en), .key_colour(key_colour),
    .bg_colour(bg_colour), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(rdy_n), .DE(de_n), .HSYNC(hs_n),
    .VSYNC(vs_n), .data(data_n), .frame_start(fs_n),
    .underflow(uf_n), .sync_err(se_n),
    .config_err(ce_n)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  logic [DW:0]   srcq[$];
  bit            stall = 0;
  bit            model_on = 0;
  bit            m_seek = 1;
  bit            m_en = 0;
  int            m_x = 0, m_y = 0;
  int            t = 0, frame = 0;
  int            ph, pv, pframe;
  logic [DW-1:0] pd;

  task automatic push_img();
    for (int k = 0; k < 4; k++)
      srcq.push_back({(k == 0), DW'($urandom)});
  endtask

  // One pixel clock: drive, check ready, clock, check registered pins.
  task automatic cycle();
    int h, v;
    bit act, win, bad, hs, hsx, vsx, rdy_e, hit;
    logic [DW-1:0] exp_d;
    h = t % 14;
    v = t / 14;
    if (srcq.size() > 0 && !stall) begin
      pix_valid = 1'b1;
      {pix_sof, pix_data} = srcq[0];
    end else begin
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      pix_data = '0;
    end
    bad = 0;
    if (enable && t == 0) begin
      bad = (int'(ovl_x) + 2 > 8) || (int'(ovl_y) + 2 > 4);
      m_en = ovl_en && !bad;
      m_x = int'(ovl_x);
      m_y = int'(ovl_y);
    end
    win = enable && m_en && h >= m_x && h < m_x + 2
       && v >= m_y && v < m_y + 2;
    act = enable && h < 8 && v < 4;
    hsx = enable && h >= 10 && h < 12;
    vsx = enable && v == 5;
    #1;
    hs = pix_valid && pix_ready;
    if (!enable) rdy_e = 0;
    else if (m_seek) rdy_e = !pix_sof;
    else rdy_e = win;
    hit = key_en && (pix_data == key_colour);
    if (!act) exp_d = '0;
    else if (win && !m_seek && !hit) exp_d = pix_data;
    else exp_d = bg_colour;
    if (model_on) begin
      chk("ready", pix_ready, rdy_e);
      chk("ready_n", rdy_n, rdy_e);
    end
    @(posedge clock);
    #1;
    if (hs) void'(srcq.pop_front());
    chk("de", DE, act);
    chk("hsync", HSYNC, hsx);
    chk("vsync", VSYNC, vsx);
    chk("hsync_n", hs_n, !hsx);
    chk("vsync_n", vs_n, !vsx);
    chk("de_n", de_n, act);
    chk("fstart", frame_start, enable && t == 0);
    chk("fstart_n", fs_n, enable && t == 0);
    chk("cfg_err", config_err, bad);
    chk("cfg_err_n", ce_n, bad);
    if (model_on) begin
      chk("data", data, exp_d);
      chk("data_n", data_n, exp_d);
    end
    if (!enable) m_seek = 1;
    else if (m_seek && pix_valid && pix_sof) m_seek = 0;
    ph = h;
    pv = v;
    pframe = frame;
    pd = data;
    if (!enable) begin
      t = 0;
      frame = 0;
    end else begin
      t = (t + 1) % 98;
      if (t == 0) frame++;
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] A, B, S, T, V;
    int off;
    reset = 1'b1;
    enable = 1'b0;
    ovl_en = 1'b0;
    ovl_x = '0;
    ovl_y = '0;
    key_en = 1'b0;
    key_colour = '0;
    bg_colour = 24'h102030;
    pix_sof = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    #2;
    chk("rst_de", DE, 0);
    chk("rst_hs", HSYNC, 0);
    chk("rst_hs_n", hs_n, 1);
    chk("rst_vs_n", vs_n, 1);
    chk("rst_data", data, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_se", sync_err, 0);
    chk("rst_rdy", pix_ready, 0);

    model_on = 1;
    push_img();
    push_img();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 98 * 30; i++) begin
      while (srcq.size() < 8) push_img();
      if (t == 0) begin
        ovl_x = CW'($urandom_range(0, 7));
        ovl_y = CW'($urandom_range(1, 3));
        ovl_en = ($urandom_range(0, 9) != 0);
        key_en = $urandom_range(0, 1);
        off = $urandom_range(0, 3);
        key_colour = srcq[off][DW-1:0];
        bg_colour = DW'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        ovl_x = CW'($urandom_range(0, 7));
        ovl_y = CW'($urandom_range(0, 3));
        ovl_en = $urandom_range(0, 1);
      end
      enable = !((i % 700) >= 350 && (i % 700) < 353);
      cycle();
    end
    chk("rand_uf", underflow, 0);
    chk("rand_se", sync_err, 0);

    // Source stalls at (4,1): background shown, sticky underflow.
    model_on = 0;
    A = 24'hA0A0A1;
    B = 24'hB0B0B2;
    srcq.delete();
    srcq.push_back({1'b1, A});
    srcq.push_back({1'b0, B});
    srcq.push_back({1'b0, 24'hC0C0C3});
    srcq.push_back({1'b0, 24'hD0D0D4});
    ovl_x = 3;
    ovl_y = 1;
    ovl_en = 1'b1;
    key_en = 1'b0;
    bg_colour = 24'h123456;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 98; i++) begin
      stall = (t == 18);
      cycle();
      if (ph == 3 && pv == 1) begin
        chk("uf_pixA", pd, A);
        chk("uf_flag0", underflow, 0);
      end
      if (ph == 4 && pv == 1) begin
        chk("uf_bg", pd, 24'h123456);
        chk("uf_flag1", underflow, 1);
      end
      if (ph == 3 && pv == 2) chk("uf_pixB", pd, B);
    end
    stall = 0;
    chk("uf_sticky", underflow, 1);

    // SOF on the third beat: error, then realign next frame.
    S = 24'h5A5A5A;
    T = 24'h7B7B7B;
    V = 24'h9D9D9D;
    srcq.delete();
    srcq.push_back({1'b1, A});
    srcq.push_back({1'b0, B});
    srcq.push_back({1'b1, S});
    srcq.push_back({1'b0, T});
    srcq.push_back({1'b0, 24'h8C8C8C});
    srcq.push_back({1'b0, V});
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 196; i++) begin
      cycle();
      if (pframe == 0 && ph == 4 && pv == 1) begin
        chk("se_pixB", pd, B);
        chk("se_flag0", sync_err, 0);
      end
      if (pframe == 0 && ph == 3 && pv == 2) begin
        chk("se_bg", pd, 24'h123456);
        chk("se_flag1", sync_err, 1);
      end
      if (pframe == 1 && ph == 3 && pv == 1) chk("se_pixS", pd, S);
      if (pframe == 1 && ph == 4 && pv == 1) chk("se_pixT", pd, T);
      if (pframe == 1 && ph == 4 && pv == 2) chk("se_pixV", pd, V);
    end
    chk("se_uf", underflow, 0);

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (ph == 3 && pv == 1) break;
    end
    chk("pre_de", DE, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_de", DE, 0);
    chk("ar_hs", HSYNC, 0);
    chk("ar_hs_n", hs_n, 1);
    chk("ar_vs", VSYNC, 0);
    chk("ar_data", data, 0);
    chk("ar_fs", frame_start, 0);
    chk("ar_cfg", config_err, 0);
    chk("ar_uf", underflow, 0);
    chk("ar_se", sync_err, 0);
    chk("ar_rdy", pix_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
